// File: rtl/launcher_pkg.sv
// Shared types and widths for the program launcher: FSM state encoding,
// counter widths and a saturating-increment helper.
package launcher_pkg;

  localparam int CYC_W  = 16;
  localparam int PIDX_W = 2;
  localparam int SCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (v == {CYC_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Clear,
  input  logic         Enable,
  output logic [W-1:0] Count
);

  always_ff @(posedge Clk) begin
    if (Reset || Clear) begin
      Count <= '0;
    end else if (Enable && (Count != {W{1'b1}})) begin
      Count <= Count + 1'b1;
    end
  end

endmodule

// File: rtl/prog_launcher.sv
// Runs NUM_PROGS programs per Go request: strobe Core_Start, count RUN cycles
// until Core_Ack, report each result. Optional watchdog: PROG_LAUNCHER_TIMEOUT_EN.
module prog_launcher
  import launcher_pkg::*;
#(
  parameter int               NUM_PROGS    = 3,
  parameter int               START_CYCLES = 2,
  parameter logic [CYC_W-1:0] TIMEOUT      = 16'd4000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Go,
  input  logic              Core_Ack,
  output logic              Core_Start,
  output logic              Busy,
  output logic [PIDX_W-1:0] Prog_Idx,
  output logic              Result_Valid,
  output logic [PIDX_W-1:0] Result_Prog,
  output logic [CYC_W-1:0]  Result_Cycles,
  output logic              All_Done,
  output logic              Timeout,
  output state_t            Dbg_State
);

  state_t             state;
  state_t             stateNext;
  logic [SCNT_W-1:0]  startCnt;
  logic [CYC_W-1:0]   cycCnt;
  logic               startDone;
  logic               lastProg;
  logic               limitHit;
  logic               finish;
  logic               coreStartNext;
  logic               busyNext;
  logic               allDoneNext;

  assign startDone = (startCnt == SCNT_W'(START_CYCLES - 1));
  assign lastProg  = (Prog_Idx == PIDX_W'(NUM_PROGS - 1));
  assign finish    = (state == RUN) && (Core_Ack || limitHit);
  assign Dbg_State = state;

`ifdef PROG_LAUNCHER_TIMEOUT_EN
  // At count TIMEOUT-1 the report value (count+1) equals TIMEOUT.
  assign limitHit = (cycCnt == TIMEOUT - 16'd1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Timeout <= 1'b0;
    end else if ((state == RUN) && limitHit) begin
      Timeout <= 1'b1;
    end
  end
`else
  logic unusedTimeoutParam;
  assign unusedTimeoutParam = ^TIMEOUT;
  assign limitHit           = 1'b0;
  assign Timeout            = 1'b0;
`endif

  sat_counter #(.W(CYC_W)) u_cycle_counter (
    .Clk    (Clk),
    .Reset  (Reset),
    .Clear  (state != RUN),
    .Enable (state == RUN),
    .Count  (cycCnt)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (Go) stateNext = START;
      START:   if (startDone) stateNext = RUN;
      RUN:     if (finish) stateNext = lastProg ? DONE : START;
      DONE:    if (!Go) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output decode of the next state, registered below
  always_comb begin
    coreStartNext = (stateNext == START);
    busyNext      = (stateNext == START) || (stateNext == RUN);
    allDoneNext   = (stateNext == DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Core_Start <= 1'b0;
      Busy       <= 1'b0;
      All_Done   <= 1'b0;
    end else begin
      Core_Start <= coreStartNext;
      Busy       <= busyNext;
      All_Done   <= allDoneNext;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset || (state != START)) begin
      startCnt <= '0;
    end else if (!startDone) begin
      startCnt <= startCnt + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Prog_Idx <= '0;
    end else if ((state == IDLE) && Go) begin
      Prog_Idx <= '0;
    end else if (finish && !lastProg) begin
      Prog_Idx <= Prog_Idx + 1'b1;
    end
  end

  // A finish always leaves RUN, so Result_Valid cannot repeat back to back.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Result_Valid  <= 1'b0;
      Result_Prog   <= '0;
      Result_Cycles <= '0;
    end else begin
      Result_Valid <= finish;
      if (finish) begin
        Result_Prog   <= Prog_Idx;
        Result_Cycles <= sat_inc(cycCnt);
      end
    end
  end

endmodule

// File: tb/tb_prog_launcher.sv
// Scoreboard bench for prog_launcher: directed runs push expected results,
// a negedge monitor pops and compares every Result_Valid pulse.
module tb_prog_launcher;
  import launcher_pkg::*;

  localparam int NUM_PROGS    = 3;
  localparam int START_CYCLES = 2;
  localparam int RW           = PIDX_W + CYC_W;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              Go = 1'b0;
  logic              Core_Ack = 1'b0;
  logic              Core_Start;
  logic              Busy;
  logic [PIDX_W-1:0] Prog_Idx;
  logic              Result_Valid;
  logic [PIDX_W-1:0] Result_Prog;
  logic [CYC_W-1:0]  Result_Cycles;
  logic              All_Done;
  logic              Timeout;
  state_t            Dbg_State;

  int checks = 0;
  int failures = 0;
  logic [RW-1:0] exp_q[$];
  logic prev_valid = 1'b0;

  prog_launcher #(
    .NUM_PROGS    (NUM_PROGS),
    .START_CYCLES (START_CYCLES),
    .TIMEOUT      (16'd20)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Go            (Go),
    .Core_Ack      (Core_Ack),
    .Core_Start    (Core_Start),
    .Busy          (Busy),
    .Prog_Idx      (Prog_Idx),
    .Result_Valid  (Result_Valid),
    .Result_Prog   (Result_Prog),
    .Result_Cycles (Result_Cycles),
    .All_Done      (All_Done),
    .Timeout       (Timeout),
    .Dbg_State     (Dbg_State)
  );

  // Clock / global time bound
  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL sim_timeout: no finish within time bound");
    $fatal(1, "time bound expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every Result_Valid pulse must match the head of the queue
  always @(negedge Clk) begin
    if (Result_Valid) begin
      checks++;
      if (prev_valid) begin
        failures++;
        $display("FAIL result_pulse_width: valid high two cycles in a row");
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL result_unexpected: got prog=%0d cycles=%0d expected none",
                 Result_Prog, Result_Cycles);
      end else begin
        logic [RW-1:0] e;
        e = exp_q.pop_front();
        if ({Result_Prog, Result_Cycles} !== e) begin
          failures++;
          $display("FAIL result_value: got prog=%0d cycles=%0d expected prog=%0d cycles=%0d",
                   Result_Prog, Result_Cycles, e[RW-1:CYC_W], e[CYC_W-1:0]);
        end
      end
    end
    prev_valid <= Result_Valid;
  end

  // Driver: one program from START through the ack (or watchdog) edge
  task automatic do_prog(input int prog, input int cyc, input bit ack_in_start, input bit no_ack);
    int n;
    int guard;
    guard = 0;
    while (!Core_Start && guard < 20) begin
      tick();
      guard++;
    end
    check("core_start_seen", Core_Start, 1);
    check("prog_idx", Prog_Idx, prog);
    check("busy_start", Busy, 1);
    n = 0;
    if (ack_in_start) Core_Ack = 1'b1;
    while (Core_Start && n < 20) begin
      n++;
      tick();
    end
    Core_Ack = 1'b0;
    check("start_len", n, START_CYCLES);
    check("busy_run", Busy, 1);
    exp_q.push_back({PIDX_W'(prog), CYC_W'(cyc)});
    repeat (cyc - 1) tick();
    if (!no_ack) Core_Ack = 1'b1;
    tick();
    Core_Ack = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    Reset = 1'b0;
    check("rst_core_start", Core_Start, 0);
    check("rst_busy", Busy, 0);
    check("rst_prog_idx", Prog_Idx, 0);
    check("rst_all_done", All_Done, 0);
    check("rst_timeout", Timeout, 0);
    check("rst_result", {Result_Valid, Result_Prog, Result_Cycles}, 0);
    check("rst_state", Dbg_State, IDLE);

    // Three programs acked on RUN cycle 10, Go held high throughout
    Go = 1'b1;
    check("start_not_early", Core_Start, 0);
    tick();
    check("start_after_go", Core_Start, 1);
    do_prog(0, 10, 0, 0);
    do_prog(1, 10, 0, 0);
    do_prog(2, 10, 0, 0);
    check("done_all_done", All_Done, 1);
    check("done_busy", Busy, 0);
    check("done_prog_idx", Prog_Idx, 2);
    repeat (3) tick();
    check("done_hold_go", All_Done, 1);
    check("done_result_hold", {Result_Prog, Result_Cycles}, {2'd2, 16'd10});
    Go = 1'b0;
    tick();
    check("done_exit_all_done", All_Done, 0);
    check("done_exit_state", Dbg_State, IDLE);

    // Restart; Ack held through START, result only on RUN cycle 5
    Go = 1'b1;
    tick();
    Go = 1'b0;
    do_prog(0, 5, 1, 0);
    do_prog(1, 3, 0, 0);
    do_prog(2, 1, 0, 0);
    check("run2_all_done", All_Done, 1);
    tick();
    check("run2_idle", Dbg_State, IDLE);

    // Reset on RUN cycle 7 of program 1, with Go and Ack also high
    Go = 1'b1;
    tick();
    Go = 1'b0;
    do_prog(0, 4, 0, 0);
    begin
      int guard;
      guard = 0;
      while (!Core_Start && guard < 20) begin tick(); guard++; end
      guard = 0;
      while (Core_Start && guard < 20) begin tick(); guard++; end
    end
    check("rst_mid_prog_idx", Prog_Idx, 1);
    repeat (6) tick();
    Reset = 1'b1;
    Core_Ack = 1'b1;
    Go = 1'b1;
    tick();
    Reset = 1'b0;
    Core_Ack = 1'b0;
    Go = 1'b0;
    check("rst_mid_outputs",
          {Core_Start, Busy, Prog_Idx, Result_Valid, Result_Prog, Result_Cycles, All_Done, Timeout}, 0);
    check("rst_mid_state", Dbg_State, IDLE);
    repeat (3) tick();
    check("rst_mid_stay_idle", Busy, 0);

`ifdef PROG_LAUNCHER_TIMEOUT_EN
    // Watchdog: no ack on program 0, normal acks afterwards
    Go = 1'b1;
    tick();
    Go = 1'b0;
    do_prog(0, 20, 0, 1);
    check("wd_timeout_set", Timeout, 1);
    do_prog(1, 6, 0, 0);
    check("wd_timeout_sticky", Timeout, 1);
    do_prog(2, 2, 0, 0);
    check("wd_all_done", All_Done, 1);
    tick();
`else
    check("no_watchdog_timeout", Timeout, 0);
`endif

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_launcher.md
PROG_LAUNCHER -- requirements
Module: prog_launcher

Interface
REQ-001 Parameter NUM_PROGS, default 3: number of programs run per Go request; legal range 1..4.
REQ-002 Parameter START_CYCLES, default 2: number of cycles Core_Start is held high per program; legal range 1..15.
REQ-003 Parameter TIMEOUT, default 16'd4000: RUN-cycle limit per program, used only when the timeout watchdog is compiled in.
REQ-004 Port Clk, input, 1: clock, posedge.
REQ-005 Port Reset, input, 1: synchronous, active-high reset.
REQ-006 Port Go, input, 1: host request to run the program sequence; level-sampled.
REQ-007 Port Core_Ack, input, 1: done flag from the processor core.
REQ-008 Port Core_Start, output, 1: start strobe to the processor core.
REQ-009 Port Busy, output, 1: high in the START and RUN states.
REQ-010 Port Prog_Idx, output, 2: index of the current program.
REQ-011 Port Result_Valid, output, 1: one-cycle pulse marking a completed program.
REQ-012 Port Result_Prog, output, 2: index of the program being reported.
REQ-013 Port Result_Cycles, output, 16: RUN cycle count of the reported program.
REQ-014 Port All_Done, output, 1: high while in the DONE state.
REQ-015 Port Timeout, output, 1: sticky watchdog flag.

Function
REQ-016 The block SHALL be a four-state FSM: IDLE, START, RUN, DONE.
REQ-017 In IDLE, Go=1 SHALL cause a transition to START next cycle, with Prog_Idx=0 and the start counter cleared.
REQ-018 In START, Core_Start SHALL be 1 for exactly START_CYCLES consecutive cycles, after which the FSM SHALL enter RUN with the cycle counter set to 0.
REQ-019 In RUN, Core_Start SHALL be 0 and the cycle counter SHALL increment by 1 every cycle, saturating at 16'hFFFF with no wrap.
REQ-020 A Core_Ack=1 sample in RUN SHALL register, on the next cycle, Result_Valid=1, Result_Prog=Prog_Idx and Result_Cycles=counter+1 (saturated), so Ack on the first RUN cycle reports 1.
REQ-021 On Ack with Prog_Idx<NUM_PROGS-1, the FSM SHALL increment Prog_Idx and re-enter START.
REQ-022 On Ack with Prog_Idx=NUM_PROGS-1, the FSM SHALL enter DONE.
REQ-023 DONE SHALL hold All_Done=1 until Go=0 is sampled, then return to IDLE.
REQ-024 Go SHALL be ignored in START and RUN.
REQ-025 Core_Ack SHALL be ignored outside RUN.
REQ-026 Result_Cycles and Result_Prog SHALL hold their last value between pulses.
REQ-027 Result_Valid SHALL never be high for two consecutive cycles.
REQ-028 Core_Start and Busy SHALL be outputs of registers, not combinational decodes of inputs.

Reset
REQ-029 Reset=1 SHALL force IDLE and set all outputs to 0 on the next posedge, including mid-RUN; no partial result is reported.
REQ-030 Reset SHALL take priority over Go and Core_Ack in the same cycle.

Configuration
REQ-031 Macro PROG_LAUNCHER_TIMEOUT_EN defined: if the RUN counter reaches TIMEOUT-1 without Ack, the block SHALL set Timeout=1 (sticky until Reset), report Result_Cycles=TIMEOUT, and advance exactly as on Ack.
REQ-032 Timeout SHALL also be set by a Core_Ack arriving in the same cycle as the limit, with the result reported once.
REQ-033 Macro undefined: there is no watchdog, Timeout SHALL be tied 0, and TIMEOUT is unused.

Structure
REQ-034 Package launcher_pkg SHALL hold the FSM state enum, CYC_W=16 and PIDX_W=2.
REQ-035 One sub-module, sat_counter (CYC_W wide, with clear/enable/saturate), SHALL implement the RUN cycle counter.
REQ-036 The start-cycle counter and FSM SHALL reside in prog_launcher.

Verification
REQ-037 Reset, then Go=1 with START_CYCLES=2 -> Core_Start high for exactly 2 cycles starting 1 cycle after Go; Busy=1.
REQ-038 Ack on the 10th RUN cycle for programs 0,1,2 -> three Result_Valid pulses with Result_Prog 0,1,2, each Result_Cycles=10, then All_Done=1.
REQ-039 Ack held high through START, then dropped and reasserted on RUN cycle 5 -> exactly one result with Result_Cycles=5.
REQ-040 Reset asserted on RUN cycle 7 of program 1 -> next cycle IDLE with all outputs 0 and no Result_Valid.
REQ-041 With PROG_LAUNCHER_TIMEOUT_EN and TIMEOUT=20, no Ack -> Result_Cycles=20, Timeout=1, Prog_Idx advances; Timeout stays 1 after a later normal Ack.
REQ-042 Go held high in DONE, then dropped -> All_Done stays 1 until Go=0, then IDLE; re-raising Go restarts at Prog_Idx=0.
